// File: rtl/cordic_pkg.sv
// Shared opcodes, packet field positions and scheduler state encodings.
package cordic_pkg;

  localparam logic [3:0] OP_ROT  = 4'h0;
  localparam logic [3:0] OP_VEC  = 4'h1;
  localparam logic [3:0] OP_STAT = 4'h2;
  localparam logic [3:0] OP_ERR  = 4'hF;

  // Packet layout: opcode | job id | x | y
  localparam int OP_MSB = 47;
  localparam int OP_LSB = 44;
  localparam int ID_MSB = 43;
  localparam int ID_LSB = 32;
  localparam int X_MSB  = 31;
  localparam int X_LSB  = 16;
  localparam int Y_MSB  = 15;
  localparam int Y_LSB  = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_LATCH = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  // Rotate and vector go through the core; everything else is answered locally.
  function automatic logic is_core_op(input logic [3:0] op);
    return (op == OP_ROT) || (op == OP_VEC);
  endfunction

endpackage

// File: rtl/cordic_out_buf.sv
// Output response FIFO with occupancy count; pointers wrap modulo DEPTH.
module cordic_out_buf #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cordic_job_scheduler.sv
// Feeds decoder jobs to a fixed-latency CORDIC core and drains responses.
//
// state   | meaning
// S_IDLE  | wait for a queued job, pulse rd_en
// S_WAIT  | decoder queue read latency
// S_LATCH | capture the job packet
// S_ISSUE | issue to core or write local response once credit allows
module cordic_job_scheduler
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH   = 48,
  parameter int CORE_LATENCY = 16,
  parameter int OUT_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  q_empty,
  output logic                  rd_en,
  output logic                  core_start,
  output logic                  core_mode,
  output logic [15:0]           core_x,
  output logic [15:0]           core_y,
  input  logic                  core_done,
  input  logic [31:0]           core_res,
  input  logic                  wr_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  state_t                state, state_nx;
  logic                  rd_en_nx;
  logic [DATA_WIDTH-1:0] job;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         out_count;
  logic [15:0]           err_cnt;
  logic [15:0]           tag_sr [CORE_LATENCY];

  logic [3:0]            job_op;
  logic                  core_job;
  logic                  credit_ok;
  logic                  issue_go;
  logic                  local_go;
  logic                  done_ok;
  logic                  stale_done;
  logic                  err_inc;
  logic [3:0]            local_op;
  logic [31:0]           local_payload;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  bypass;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] head;

  assign job_op    = job[OP_MSB:OP_LSB];
  assign core_job  = is_core_op(job_op);
  // Every in-flight job owns a reserved buffer slot, so a core result always fits.
  assign credit_ok = ((CW+1)'(inflight) + (CW+1)'(out_count)) < (CW+1)'(OUT_DEPTH);
  assign issue_go  = (state == S_ISSUE) && core_job && credit_ok;
  assign local_go  = (state == S_ISSUE) && !core_job && credit_ok && !core_done
                     && (out_count < CW'(OUT_DEPTH));
  assign done_ok    = core_done && (inflight != '0);
  assign stale_done = core_done && (inflight == '0);
  assign err_inc    = stale_done || (local_go && (job_op != OP_STAT));

  assign local_op      = (job_op == OP_STAT) ? OP_STAT : OP_ERR;
  assign local_payload = (job_op == OP_STAT) ? {err_cnt, 8'(inflight), 8'(out_count)}
                                             : job[X_MSB:Y_LSB];

  // Core completions win the single buffer write port.
  assign push_valid = done_ok || local_go;
  assign push_data  = done_ok ? {tag_sr[CORE_LATENCY-1], core_res}
                              : {local_op, job[ID_MSB:ID_LSB], local_payload};
  // With an empty buffer the response goes straight to the write register.
  assign bypass     = push_valid && (out_count == '0) && !wr_full;
  assign fifo_push  = push_valid && !bypass;
  assign fifo_pop   = (out_count != '0) && !wr_full;

  cordic_out_buf #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .count     (out_count)
  );

  // Next-state and read-strobe decode.
  always_comb begin
    state_nx = state;
    rd_en_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          rd_en_nx = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT:  state_nx = S_LATCH;
      S_LATCH: state_nx = S_ISSUE;
      S_ISSUE: if (issue_go || local_go) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and registered control/data outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_en      <= 1'b0;
      core_start <= 1'b0;
      core_mode  <= 1'b0;
      core_x     <= '0;
      core_y     <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      job        <= '0;
    end else begin
      state      <= state_nx;
      rd_en      <= rd_en_nx;
      core_start <= issue_go;
      if (issue_go) begin
        core_mode <= job_op[0];
        core_x    <= job[X_MSB:X_LSB];
        core_y    <= job[Y_MSB:Y_LSB];
      end
      if (state == S_LATCH) job <= in_data;
      wr_en <= bypass || fifo_pop;
      if (bypass)        wr_data <= push_data;
      else if (fifo_pop) wr_data <= head;
    end
  end

  // Tag pipeline tracks the core; the job register is stable while core_start is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CORE_LATENCY; i++) tag_sr[i] <= '0;
    end else begin
      tag_sr[0] <= core_start ? {job_op, job[ID_MSB:ID_LSB]} : 16'h0000;
      for (int i = 1; i < CORE_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  // In-flight and error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      err_cnt  <= '0;
    end else begin
      case ({core_start, done_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
